// File: rtl/if_fetch_pkg.sv
// Constants shared by the instruction-fetch front end: stall-request levels,
// stall-vector bit positions, the NOP encoding and the default reset PC.
package if_fetch_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, keeps one request outstanding to
// the instruction ROM and buffers one fetched instruction for IF_ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [5:0]        stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [31:0]       rom_data_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_valid_o,
  output logic              stallreq_from_if_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              kill;

  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_plus4;
  logic              consume;
  logic              unused_bits;

  // ROM handshake: rom_req_o rises with rom_addr_o and both stay frozen until
  // the cycle rom_ack_i=1, which retires the request; at most one is in flight.
  // IF_ID side: inst_valid_o is the valid, !stall_i[STALL_IF] is the ready.
  assign target      = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign pc_plus4    = rom_addr_o + ADDR_W'(4);
  assign consume     = inst_valid_o && !stall_i[STALL_IF];
  assign unused_bits = ^{stall_i[5:2], branch_target_i[1:0]};

  assign stallreq_from_if_o = inst_valid_o ? NOSTOP : STOP;
  assign state_o            = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rom_req_o    <= 1'b0;
      rom_addr_o   <= RESET_PC;
      inst_o       <= NOP_INST;
      pc_o         <= RESET_PC;
      inst_valid_o <= 1'b0;
      fetch_pc     <= RESET_PC;
      kill         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_flag_i) begin
            fetch_pc <= target;
          end else if (!stall_i[STALL_PC]) begin
            rom_req_o  <= 1'b1;
            rom_addr_o <= fetch_pc;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (rom_ack_i) begin
            rom_req_o <= 1'b0;
            kill      <= 1'b0;
            if (branch_flag_i) begin
              fetch_pc <= target;
              state    <= IDLE;
            end else if (kill) begin
              state <= IDLE;
            end else begin
              inst_o       <= rom_data_i;
              pc_o         <= rom_addr_o;
              inst_valid_o <= 1'b1;
              fetch_pc     <= pc_plus4;
              state        <= FULL;
            end
          end else if (branch_flag_i) begin
            // The request cannot be withdrawn; its data is dropped on arrival.
            kill     <= 1'b1;
            fetch_pc <= target;
          end
        end
        FULL: begin
          if (branch_flag_i) begin
            inst_valid_o <= 1'b0;
            fetch_pc     <= target;
            state        <= IDLE;
          end else if (consume) begin
            inst_valid_o <= 1'b0;
            if (!stall_i[STALL_PC]) begin
              rom_req_o  <= 1'b1;
              rom_addr_o <= fetch_pc;
              state      <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a behavioural variable-latency ROM.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        stallreq;
  logic [1:0]  state;

  int compared;
  int mismatched;
  int lat;
  int cnt;

  if_fetch dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .stall_i            (stall),
    .branch_flag_i      (branch_flag),
    .branch_target_i    (branch_target),
    .rom_req_o          (rom_req),
    .rom_addr_o         (rom_addr),
    .rom_ack_i          (rom_ack),
    .rom_data_i         (rom_data),
    .inst_o             (inst),
    .pc_o               (pc),
    .inst_valid_o       (inst_valid),
    .stallreq_from_if_o (stallreq),
    .state_o            (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return {16'hC0DE, a[15:0]};
  endfunction

  // ROM answers lat cycles after it first sees the request, one ack per request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ack  <= 1'b0;
      rom_data <= 32'h0;
      cnt      <= 0;
    end else begin
      rom_ack <= 1'b0;
      if (rom_req && !rom_ack) begin
        if (cnt >= lat - 1) begin
          rom_ack  <= 1'b1;
          rom_data <= rom_word(rom_addr);
          cnt      <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int guard;
    guard = 0;
    while (rom_req !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    check({tag, "_req_seen"}, {31'b0, rom_req}, 32'd1);
    check({tag, "_req_addr"}, rom_addr, exp_addr);
  endtask

  task automatic wait_ack(input string tag);
    int guard;
    guard = 0;
    while (rom_ack !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    check({tag, "_ack_seen"}, {31'b0, rom_ack}, 32'd1);
  endtask

  task automatic finish_fetch(input string tag, input logic [31:0] a, input int exp_held);
    int held;
    held = 0;
    while (rom_ack !== 1'b1 && held < 40) begin
      check({tag, "_req_hold"}, {31'b0, rom_req}, 32'd1);
      check({tag, "_addr_stable"}, rom_addr, a);
      held++;
      step();
    end
    check({tag, "_held_cycles"}, held, exp_held);
    step();
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, "_pc"}, pc, a);
    check({tag, "_inst"}, inst, rom_word(a));
    check({tag, "_stallreq"}, {31'b0, stallreq}, 32'd0);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    lat           = 1;
    rst           = 1'b1;
    stall         = 6'b0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    repeat (2) step();

    check("rst_req", {31'b0, rom_req}, 32'd0);
    check("rst_addr", rom_addr, 32'h0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_stallreq", {31'b0, stallreq}, 32'd1);
    check("rst_state", {30'b0, state}, 32'd0);

    // Reset release, 1-cycle ROM: request in cycle 1, valid in cycle 3.
    rst = 1'b0;
    step();
    check("c1_req", {31'b0, rom_req}, 32'd1);
    check("c1_addr", rom_addr, 32'h0);
    step();
    check("c2_valid", {31'b0, inst_valid}, 32'd0);
    check("c2_stallreq", {31'b0, stallreq}, 32'd1);
    step();
    check("c3_valid", {31'b0, inst_valid}, 32'd1);
    check("c3_pc", pc, 32'h0);
    check("c3_inst", inst, 32'h00A0_0093);
    check("c3_stallreq", {31'b0, stallreq}, 32'd0);

    // Straight-line fetch with a 3-cycle ROM.
    lat = 3;
    wait_req("f4", 32'h4);
    finish_fetch("f4", 32'h4, 3);
    wait_req("f8", 32'h8);
    stall = 6'b000111;
    finish_fetch("f8", 32'h8, 3);

    // Held in FULL under stall: buffer frozen, no new request.
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc", pc, 32'h8);
      check("stall_inst", inst, rom_word(32'h8));
      check("stall_valid", {31'b0, inst_valid}, 32'd1);
      check("stall_req", {31'b0, rom_req}, 32'd0);
    end
    stall = 6'b0;
    wait_req("fc", 32'hC);
    finish_fetch("fc", 32'hC, 3);

    // Redirect while waiting for 0x10: request completes, data is dropped.
    wait_req("f10", 32'h10);
    branch_flag   = 1'b1;
    branch_target = 32'h100;
    step();
    branch_flag = 1'b0;
    check("kill_req_kept", {31'b0, rom_req}, 32'd1);
    check("kill_addr_kept", rom_addr, 32'h10);
    wait_ack("kill");
    step();
    check("kill_valid", {31'b0, inst_valid}, 32'd0);
    check("kill_state", {30'b0, state}, 32'd0);
    check("kill_pc_kept", pc, 32'hC);
    wait_req("f100", 32'h100);
    finish_fetch("f100", 32'h100, 3);

    // Redirect coincident with ack: data dropped, low bits of target cleared.
    wait_req("f104", 32'h104);
    wait_ack("coinc");
    branch_flag   = 1'b1;
    branch_target = 32'h203;
    step();
    branch_flag = 1'b0;
    check("coinc_valid", {31'b0, inst_valid}, 32'd0);
    check("coinc_state", {30'b0, state}, 32'd0);
    check("coinc_pc_kept", pc, 32'h100);
    wait_req("f200", 32'h200);
    finish_fetch("f200", 32'h200, 3);

    // Redirect from FULL to the top of the address space, then wrap.
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_flag = 1'b0;
    check("full_redir_valid", {31'b0, inst_valid}, 32'd0);
    check("full_redir_state", {30'b0, state}, 32'd0);
    wait_req("ftop", 32'hFFFF_FFFC);
    finish_fetch("ftop", 32'hFFFF_FFFC, 3);
    wait_req("fwrap", 32'h0);

    // Asynchronous reset in the middle of WAIT.
    step();
    check("midwait_state", {30'b0, state}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_req", {31'b0, rom_req}, 32'd0);
    check("arst_addr", rom_addr, 32'h0);
    check("arst_valid", {31'b0, inst_valid}, 32'd0);
    check("arst_state", {30'b0, state}, 32'd0);
    check("arst_stallreq", {31'b0, stallreq}, 32'd1);
    step();
    rst = 1'b0;
    wait_req("frst", 32'h0);
    finish_fetch("frst", 32'h0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
